jericalla_instr_issuer: RTL and testbench
=========================================

// Module: jericalla_instr_issuer
// PURPOSE
//  Producer side of the 17-bit instruction interface consumed by the JericallaEvo core.
//  Holds a loadable program store and steps a program counter through it.
//  Presents one instruction per cycle on a valid/ready handshake.
//  Optionally inserts bubbles so that no instruction reads a register still in the core's two buffer stages.
// PARAMETERS
//  PROG_DEPTH     64                   program store entries
//  ADDR_W         $clog2(PROG_DEPTH)   program counter / load address width
//  INSTR_W        17                   instruction width {op[16:15],rd[14:10],rs1[9:5],rs2[4:0]}
//  HAZARD_WINDOW  2                    issued-write slots tracked; equals the core buffer depth
// PORTS
//  clock         in   1        single clock, rising edge
//  reset_n       in   1        asynchronous, active-low reset
//  load_enable   in   1        write load_data to the program store; ignored while busy
//  load_addr     in   ADDR_W   program store write address
//  load_data     in   INSTR_W  instruction to store
//  start         in   1        one-cycle pulse; latches prog_length and begins issue; ignored while busy
//  prog_length   in   ADDR_W+1 number of instructions to issue (0..PROG_DEPTH)
//  core_ready    in   1        core accepts instruction this cycle
//  instruction   out  INSTR_W  issued instruction, registered
//  issue_valid   out  1        instruction is meaningful; low = bubble
//  pc            out  ADDR_W   address of the instruction currently presented
//  busy          out  1        high from start acceptance until done
//  done          out  1        one-cycle pulse when the program and the drain are complete
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; instruction=0; issue_valid=0; pc=0; busy=0; done=0; scoreboard cleared.
//    The program store is not cleared.
//  - FSM states and transitions:
//    - IDLE:  start & prog_length>0 -> RUN.
//             start & prog_length==0 -> DRAIN (busy for HAZARD_WINDOW cycles, then done).
//    - RUN:   presents store[pc].
//             Transfer occurs on issue_valid & core_ready; pc increments on each transfer.
//             Last transfer (pc==prog_length-1) -> DRAIN.
//             Hazard on next instruction -> STALL.
//    - STALL: issue_valid=0; instruction is unchanged; scoreboard shifts in empty slots.
//             Returns to RUN in the cycle after the hazard clears.
//    - DRAIN: issue_valid=0 for HAZARD_WINDOW cycles, then done=1 for one cycle -> IDLE with busy=0.
//  - Latency: start accepted in cycle 0 -> first issue_valid=1 in cycle 1 (store read is registered).
//    Independent instructions issue back-to-back, one per cycle.
//  - Handshake:
//    - While issue_valid=1 and core_ready=0, instruction, pc and issue_valid hold stable.
//    - The scoreboard shifts only on transfer or bubble cycles, never on a held cycle.
//  - Writes to rd: opcodes 2'b00, 2'b01 and 2'b10 write rd. Opcode 2'b11 writes no register.
//  - Hazard: rs1 or rs2 equals the rd of any valid scoreboard slot. Register 0 is not special.
//  - Load while busy is dropped. A start coincident with done is ignored.
//  - pc wraps only via prog_length. prog_length > PROG_DEPTH saturates to PROG_DEPTH.
// CONFIGURATION
//  - ISSUER_INTERLOCK_EN defined: scoreboard present and STALL state reachable, as specified above.
//  - ISSUER_INTERLOCK_EN undefined:
//    - No scoreboard and no STALL state; instructions issue every core_ready cycle.
//    - Software must schedule independent instructions; DRAIN timing is unchanged.
// STRUCTURE
//  - Package jericalla_pkg:
//    - opcode localparams (OP_0..OP_3) and the writes_rd function;
//    - instruction field bit positions;
//    - state encoding typedef (IDLE/RUN/STALL/DRAIN).
//  - Sub-module issue_scoreboard:
//    - HAZARD_WINDOW-deep shift register of {valid, rd};
//    - inputs shift_en, push_valid, push_rd, rs1, rs2; output hazard.
//  - Top contains the program store array, pc and FSM.
// TESTING
//  - Load 3 independent instructions (e.g. 17'b00_00100_00000_00001, 17'b01_00101_00010_00011, 17'b11_00000_00111_00110).
//    Pulse start with prog_length=3, core_ready=1.
//    -> issue_valid in cycles 1..3 with pc 0,1,2; done pulse in cycle 6.
//  - Interlock on: 17'b00_00100_00000_00001 then 17'b01_00101_00100_00010.
//    -> exactly 2 bubble cycles between them; same program with the macro off -> 0 bubbles.
//  - Drop core_ready for 3 cycles while pc=1 -> instruction and pc hold; no scoreboard shift; issue resumes with pc 1.
//  - Pulse start with prog_length=0 -> busy for 2 cycles, done pulse, issue_valid never high.
//  - Assert reset_n low mid-RUN at pc=2 -> all outputs 0 immediately.
//    Restart -> program re-issues from pc 0 with store contents intact.
//  - load_enable and start while busy -> no store change; the current run completes unaffected.

Source files
------------

// File: rtl/jericalla_pkg.sv
// rtl/jericalla_pkg.sv - shared constants, instruction field helpers and FSM encoding for the issuer
package jericalla_pkg;

  localparam int DEF_PROG_DEPTH    = 64;
  localparam int DEF_ADDR_W        = $clog2(DEF_PROG_DEPTH);
  localparam int DEF_HAZARD_WINDOW = 2;
  localparam int INSTR_W           = 17;
  localparam int REG_W             = 5;

  localparam logic [1:0] OP_0 = 2'b00;
  localparam logic [1:0] OP_1 = 2'b01;
  localparam logic [1:0] OP_2 = 2'b10;
  localparam logic [1:0] OP_3 = 2'b11;

  localparam int OP_HI  = 16;
  localparam int OP_LO  = 15;
  localparam int RD_HI  = 14;
  localparam int RD_LO  = 10;
  localparam int RS1_HI = 9;
  localparam int RS1_LO = 5;
  localparam int RS2_HI = 4;
  localparam int RS2_LO = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // OP_3 is the only opcode that leaves the register file untouched
  function automatic logic writes_rd(input logic [1:0] op);
    return (op == OP_0) || (op == OP_1) || (op == OP_2);
  endfunction

  function automatic logic [1:0] get_op(input logic [INSTR_W-1:0] instr);
    return instr[OP_HI:OP_LO];
  endfunction

  function automatic logic [REG_W-1:0] get_rd(input logic [INSTR_W-1:0] instr);
    return instr[RD_HI:RD_LO];
  endfunction

  function automatic logic [REG_W-1:0] get_rs1(input logic [INSTR_W-1:0] instr);
    return instr[RS1_HI:RS1_LO];
  endfunction

  function automatic logic [REG_W-1:0] get_rs2(input logic [INSTR_W-1:0] instr);
    return instr[RS2_HI:RS2_LO];
  endfunction

endpackage

// File: rtl/jericalla_instr_issuer_if.sv
// rtl/jericalla_instr_issuer_if.sv - program load, start control and instruction issue signals
interface jericalla_instr_issuer_if #(
  parameter int ADDR_W = jericalla_pkg::DEF_ADDR_W
);

  logic                           load_enable;
  logic [ADDR_W-1:0]              load_addr;
  logic [jericalla_pkg::INSTR_W-1:0] load_data;
  logic                           start;
  logic [ADDR_W:0]                prog_length;
  logic                           core_ready;
  logic [jericalla_pkg::INSTR_W-1:0] instruction;
  logic                           issue_valid;
  logic [ADDR_W-1:0]              pc;
  logic                           busy;
  logic                           done;

  modport master (
    input  load_enable, load_addr, load_data, start, prog_length, core_ready,
    output instruction, issue_valid, pc, busy, done
  );

  modport slave (
    output load_enable, load_addr, load_data, start, prog_length, core_ready,
    input  instruction, issue_valid, pc, busy, done
  );

endinterface

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - shift register of recently issued destination registers with hazard compare
module issue_scoreboard
  import jericalla_pkg::*;
#(
  parameter int HAZARD_WINDOW = DEF_HAZARD_WINDOW
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             shift_en,
  input  logic             push_valid,
  input  logic [REG_W-1:0] push_rd,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  output logic             hazard
);

  logic [HAZARD_WINDOW-1:0]            slot_valid;
  logic [HAZARD_WINDOW-1:0][REG_W-1:0] slot_rd;
  logic [HAZARD_WINDOW-1:0]            view_valid;
  logic [HAZARD_WINDOW-1:0][REG_W-1:0] view_rd;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid <= '0;
      slot_rd    <= '0;
    end else if (shift_en) begin
      slot_valid[0] <= push_valid;
      slot_rd[0]    <= push_rd;
      for (int i = 1; i < HAZARD_WINDOW; i++) begin
        slot_valid[i] <= slot_valid[i-1];
        slot_rd[i]    <= slot_rd[i-1];
      end
    end
  end

  // Compare against the window as it will stand after this cycle's shift,
  // since that is what the instruction loaded now will meet in the core.
  always_comb begin
    view_valid = slot_valid;
    view_rd    = slot_rd;
    hazard     = 1'b0;
    if (shift_en) begin
      view_valid[0] = push_valid;
      view_rd[0]    = push_rd;
      for (int i = 1; i < HAZARD_WINDOW; i++) begin
        view_valid[i] = slot_valid[i-1];
        view_rd[i]    = slot_rd[i-1];
      end
    end
    for (int i = 0; i < HAZARD_WINDOW; i++) begin
      if (view_valid[i] && ((view_rd[i] == rs1) || (view_rd[i] == rs2))) begin
        hazard = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jericalla_instr_issuer.sv
// rtl/jericalla_instr_issuer.sv - program store, pc and issue FSM feeding the JericallaEvo core
// ISSUER_INTERLOCK_EN adds the scoreboard and the STALL path that bubbles around RAW hazards.
module jericalla_instr_issuer
  import jericalla_pkg::*;
#(
  parameter int PROG_DEPTH    = DEF_PROG_DEPTH,
  parameter int HAZARD_WINDOW = DEF_HAZARD_WINDOW
) (
  input  logic                     clock,
  input  logic                     reset_n,
  jericalla_instr_issuer_if.master bus
);

  localparam int ADDR_W = $clog2(PROG_DEPTH);
  localparam int LEN_W  = ADDR_W + 1;
  localparam int CNT_W  = $clog2(HAZARD_WINDOW + 1);

  logic [INSTR_W-1:0] store [PROG_DEPTH];

  state_t             state, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [LEN_W-1:0]   len_in;
  logic [ADDR_W-1:0]  rd_addr;
  logic [INSTR_W-1:0] rd_data;
  logic               transfer;
  logic               is_last;
  logic               hazard;

  always_ff @(posedge clock) begin
    if (bus.load_enable && !busy_q) begin
      store[bus.load_addr] <= bus.load_data;
    end
  end

  assign len_in   = (bus.prog_length > LEN_W'(PROG_DEPTH)) ? LEN_W'(PROG_DEPTH) : bus.prog_length;
  assign transfer = (state == RUN) && valid_q && bus.core_ready;
  assign is_last  = ({1'b0, pc_q} == (len_q - LEN_W'(1)));

  // Address of the instruction that would be presented next cycle.
  always_comb begin
    rd_addr = '0;
    case (state)
      IDLE:    rd_addr = '0;
      RUN:     rd_addr = pc_q + ADDR_W'(1);
      STALL:   rd_addr = pc_q;
      default: rd_addr = pc_q;
    endcase
  end

  assign rd_data = store[rd_addr];

`ifdef ISSUER_INTERLOCK_EN
  logic shift_en;
  logic push_valid;

  // A held cycle (valid but not accepted) must not age the window.
  assign shift_en   = !((state == RUN) && !bus.core_ready);
  assign push_valid = transfer && writes_rd(get_op(instr_q));

  issue_scoreboard #(
    .HAZARD_WINDOW(HAZARD_WINDOW)
  ) u_scoreboard (
    .clock      (clock),
    .reset_n    (reset_n),
    .shift_en   (shift_en),
    .push_valid (push_valid),
    .push_rd    (get_rd(instr_q)),
    .rs1        (get_rs1(rd_data)),
    .rs2        (get_rs2(rd_data)),
    .hazard     (hazard)
  );
`else
  assign hazard = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      instr_q <= '0;
      valid_q <= 1'b0;
      pc_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state   <= state_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    instr_d = instr_q;
    valid_d = valid_q;
    pc_d    = pc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state)
      IDLE: begin
        // done_q marks the completion cycle, where a new start is refused
        if (bus.start && !done_q) begin
          busy_d = 1'b1;
          len_d  = len_in;
          pc_d   = '0;
          cnt_d  = '0;
          if (len_in == '0) begin
            state_d = DRAIN;
          end else if (hazard) begin
            state_d = STALL;
            valid_d = 1'b0;
          end else begin
            state_d = RUN;
            instr_d = rd_data;
            valid_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (transfer) begin
          if (is_last) begin
            state_d = DRAIN;
            valid_d = 1'b0;
            cnt_d   = '0;
          end else begin
            pc_d = pc_q + ADDR_W'(1);
            if (hazard) begin
              state_d = STALL;
              valid_d = 1'b0;
            end else begin
              instr_d = rd_data;
            end
          end
        end
      end
      STALL: begin
        if (!hazard) begin
          state_d = RUN;
          instr_d = rd_data;
          valid_d = 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_W'(HAZARD_WINDOW - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pc_d    = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.instruction = instr_q;
  assign bus.issue_valid = valid_q;
  assign bus.pc          = pc_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_jericalla_instr_issuer.sv
// tb/tb_jericalla_instr_issuer.sv - scoreboard bench for the instruction issuer
module tb_jericalla_instr_issuer;

  typedef struct {
    logic [5:0]  pc;
    logic [16:0] instr;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  exp_t        exp_q[$];
  int          issue_cyc[$];
  logic [31:0] issue_mask;
  int          done_cyc;
  int          busy_cnt;
  logic        valid_seen;
  logic [16:0] prog [8];

  jericalla_instr_issuer_if bus ();

  jericalla_instr_issuer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load_prog(input int n, input logic [16:0] p0, input logic [16:0] p1, input logic [16:0] p2);
    prog[0] = p0;
    prog[1] = p1;
    prog[2] = p2;
    for (int i = 0; i < n; i++) begin
      bus.load_enable = 1'b1;
      bus.load_addr   = 6'(i);
      bus.load_data   = prog[i];
      step();
    end
    bus.load_enable = 1'b0;
  endtask

  task automatic start_prog(input int len);
    exp_t e;
    for (int i = 0; i < len; i++) begin
      e.pc    = 6'(i);
      e.instr = prog[i];
      exp_q.push_back(e);
    end
    bus.start = 1'b0;
    step();
    bus.start       = 1'b1;
    bus.prog_length = 7'(len);
    step();
    bus.start = 1'b0;
  endtask

  // Observes cycles 1.. after a start until done; cycle n is the n-th sample after the start edge.
  task automatic watch(input int drop_from, input int drop_len, input int inject_at, input int stop_at);
    int          c;
    exp_t        e;
    logic [16:0] prev_instr;
    logic [5:0]  prev_pc;
    c = 1;
    issue_cyc.delete();
    issue_mask = '0;
    done_cyc   = -1;
    busy_cnt   = 0;
    valid_seen = 1'b0;
    prev_instr = '0;
    prev_pc    = '0;
    while (c < 200) begin
      if (c == stop_at) return;
      bus.core_ready = !(c >= drop_from && c < drop_from + drop_len);
      if (c == inject_at) begin
        bus.load_enable = 1'b1;
        bus.load_addr   = 6'd0;
        bus.load_data   = 17'h1ffff;
        bus.start       = 1'b1;
        bus.prog_length = 7'd1;
      end else begin
        bus.load_enable = 1'b0;
        bus.start       = 1'b0;
      end
      if (bus.busy) busy_cnt++;
      if (bus.issue_valid) valid_seen = 1'b1;
      if (bus.issue_valid && !bus.core_ready && c > drop_from) begin
        checks++;
        if (bus.pc !== prev_pc || bus.instruction !== prev_instr) begin
          failures++;
          $display("FAIL held_cycle c=%0d pc=%0d instr=%h required pc=%0d instr=%h",
                   c, bus.pc, bus.instruction, prev_pc, prev_instr);
        end
      end
      if (bus.issue_valid && bus.core_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_issue c=%0d pc=%0d instr=%h required none", c, bus.pc, bus.instruction);
        end else begin
          e = exp_q.pop_front();
          if (bus.pc !== e.pc || bus.instruction !== e.instr) begin
            failures++;
            $display("FAIL issue c=%0d pc=%0d instr=%h required pc=%0d instr=%h",
                     c, bus.pc, bus.instruction, e.pc, e.instr);
          end
        end
        issue_cyc.push_back(c);
        issue_mask[c] = 1'b1;
      end
      if (bus.done) begin
        done_cyc = c;
        break;
      end
      prev_pc    = bus.pc;
      prev_instr = bus.instruction;
      step();
      c++;
    end
    bus.core_ready = 1'b1;
    checks++;
    if (done_cyc < 0) begin
      failures++;
      $display("FAIL done_timeout cycles=%0d required done within 200", c);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_expected count=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    bus.load_enable = 1'b0;
    bus.load_addr   = '0;
    bus.load_data   = '0;
    bus.start       = 1'b0;
    bus.prog_length = '0;
    bus.core_ready  = 1'b1;
    reset_n = 1'b0;
    step();
    step();
    checks++;
    if (bus.instruction !== 17'd0 || bus.issue_valid !== 1'b0 || bus.pc !== 6'd0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state instr=%h valid=%b pc=%0d busy=%b done=%b required all 0",
               bus.instruction, bus.issue_valid, bus.pc, bus.busy, bus.done);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    load_prog(3, 17'b00_00100_00000_00001, 17'b01_00101_00010_00011, 17'b11_00000_00111_00110);
    start_prog(3);
    watch(0, 0, 0, 0);
    checks++;
    if (issue_mask !== 32'h0000_000e) begin
      failures++;
      $display("FAIL basic_issue_cycles mask=%h required 0000000e", issue_mask);
    end
    checks++;
    if (done_cyc != 6 || busy_cnt != 5) begin
      failures++;
      $display("FAIL basic_done done_cycle=%0d busy_cycles=%0d required 6 and 5", done_cyc, busy_cnt);
    end
    bus.start       = 1'b1;
    bus.prog_length = 7'd3;
    step();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.issue_valid !== 1'b0) begin
      failures++;
      $display("FAIL start_on_done busy=%b valid=%b required 0 0", bus.busy, bus.issue_valid);
    end
  endtask

  task automatic test_hazard();
    int exp_bubbles;
    logic [31:0] exp_mask;
    int exp_done;
`ifdef ISSUER_INTERLOCK_EN
    exp_bubbles = 2;
    exp_mask    = 32'h0000_0012;
    exp_done    = 7;
`else
    exp_bubbles = 0;
    exp_mask    = 32'h0000_0006;
    exp_done    = 5;
`endif
    load_prog(2, 17'b00_00100_00000_00001, 17'b01_00101_00100_00010, 17'd0);
    start_prog(2);
    watch(0, 0, 0, 0);
    checks++;
    if (issue_cyc.size() != 2 || issue_cyc[1] - issue_cyc[0] - 1 != exp_bubbles) begin
      failures++;
      $display("FAIL hazard_bubbles issued=%0d mask=%h required %0d bubbles", issue_cyc.size(), issue_mask, exp_bubbles);
    end
    checks++;
    if (issue_mask !== exp_mask || done_cyc != exp_done) begin
      failures++;
      $display("FAIL hazard_timing mask=%h done=%0d required %h %0d", issue_mask, done_cyc, exp_mask, exp_done);
    end
  endtask

  task automatic test_ready_hold();
    logic [31:0] exp_mask;
`ifdef ISSUER_INTERLOCK_EN
    exp_mask = 32'h0000_00a2;
`else
    exp_mask = 32'h0000_0062;
`endif
    load_prog(3, 17'b00_00100_00000_00001, 17'b11_00000_00111_00110, 17'b01_00101_00100_00010);
    start_prog(3);
    watch(2, 3, 0, 0);
    checks++;
    if (issue_mask !== exp_mask) begin
      failures++;
      $display("FAIL ready_hold_cycles mask=%h required %h", issue_mask, exp_mask);
    end
  endtask

  task automatic test_zero_length();
    start_prog(0);
    watch(0, 0, 0, 0);
    checks++;
    if (busy_cnt != 2 || done_cyc != 3 || valid_seen !== 1'b0) begin
      failures++;
      $display("FAIL zero_length busy=%0d done=%0d valid_seen=%b required 2 3 0", busy_cnt, done_cyc, valid_seen);
    end
  endtask

  task automatic test_reset_mid_run();
    load_prog(3, 17'b00_00100_00000_00001, 17'b01_00101_00010_00011, 17'b11_00000_00111_00110);
    start_prog(3);
    watch(0, 0, 0, 3);
    checks++;
    if (bus.pc !== 6'd2 || bus.issue_valid !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset pc=%0d valid=%b required 2 1", bus.pc, bus.issue_valid);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.instruction !== 17'd0 || bus.issue_valid !== 1'b0 || bus.pc !== 6'd0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset instr=%h valid=%b pc=%0d busy=%b done=%b required all 0",
               bus.instruction, bus.issue_valid, bus.pc, bus.busy, bus.done);
    end
    exp_q.delete();
    step();
    reset_n = 1'b1;
    start_prog(3);
    watch(0, 0, 0, 0);
    checks++;
    if (issue_mask !== 32'h0000_000e || done_cyc != 6) begin
      failures++;
      $display("FAIL restart mask=%h done=%0d required 0000000e 6", issue_mask, done_cyc);
    end
  endtask

  task automatic test_busy_inputs();
    load_prog(3, 17'b00_00100_00000_00001, 17'b01_00101_00010_00011, 17'b11_00000_00111_00110);
    start_prog(3);
    watch(0, 0, 2, 0);
    checks++;
    if (issue_mask !== 32'h0000_000e || done_cyc != 6) begin
      failures++;
      $display("FAIL busy_inputs_run mask=%h done=%0d required 0000000e 6", issue_mask, done_cyc);
    end
    start_prog(1);
    watch(0, 0, 0, 0);
    checks++;
    if (issue_mask !== 32'h0000_0002) begin
      failures++;
      $display("FAIL store_intact mask=%h required 00000002", issue_mask);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hazard();
    test_ready_hold();
    test_zero_length();
    test_reset_mid_run();
    test_busy_inputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
